xgmii_rx_frame_parser: RTL and testbench

Receive-side stage that consumes the raw 64-bit XGMII RX stream (xgmii_N_rxd/rxc) and feeds the measurement logic. It delineates frames between Start and Terminate control characters and reports length and error status per frame. It also extracts a 64-bit tag (sequence number or timestamp) at a fixed byte offset, and keeps frame, byte, runt and error statistics. One instance per port, running in the sys_clk (156.25 MHz) domain.

---
 rtl/xgmii_rx_frame_parser.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_xgmii_rx_frame_parser.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_rx_frame_parser.sv
// xgmii_rx_frame_parser
//   Delineates frames on a 64-bit XGMII RX stream. For each frame it reports
//   the length (first DA byte through FCS), an error flag and an optional
//   64-bit tag taken from a fixed byte offset. It also keeps frame, byte,
//   runt and error statistics.
//
//   Optional build macro: XGMII_LANE4_START_EN
//     When defined, a Start character in lane 4 is also accepted. The stream
//     is then realigned by 4 bytes, and end-of-frame reporting for those
//     frames is uniformly 2 cycles after the terminating word.
//     When undefined, FB in lane 4 is an ordinary control character.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | between frames, waiting for a Start character
//   S_DATA | inside a frame, counting bytes until Terminate or an error

module xgmii_rx_frame_parser #(
    parameter int TS_OFFSET = 40,
    parameter int MIN_LEN   = 64,
    parameter int CNT_W     = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [63:0]      xgmii_rxd,
    input  logic [7:0]       xgmii_rxc,
    input  logic             stats_clr,
    output logic             frame_valid,
    output logic [15:0]      frame_len,
    output logic             frame_err,
    output logic             tag_valid,
    output logic [63:0]      tag_value,
    output logic             in_frame,
    output logic [CNT_W-1:0] rx_frames,
    output logic [CNT_W-1:0] rx_bytes,
    output logic [CNT_W-1:0] rx_runts,
    output logic [CNT_W-1:0] rx_errors
);

    localparam logic [7:0] C_START = 8'hFB;
    localparam logic [7:0] C_TERM  = 8'hFD;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DATA = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic        sat_q, sat_d;
    logic [63:0] tag_q, tag_d;
    logic        tag_hit_q, tag_hit_d;

    logic [63:0] eff_rxd;
    logic [7:0]  eff_rxc;
    logic        ctl_found;
    logic [2:0]  ctl_lane;
    logic [7:0]  ctl_byte;
    logic        start_l0;
    logic        process_word;

    logic [16:0] sum_word;
    logic [16:0] sum_lane;
    logic [15:0] cnt_plus8;
    logic [15:0] len_lane;

    logic        emit;
    logic        emit_now;
    logic [15:0] emit_len;
    logic        emit_err;

`ifdef XGMII_LANE4_START_EN
    logic        align_q, align_d;
    logic        skip_q, skip_d;
    logic [31:0] hold_rxd_q;
    logic [3:0]  hold_rxc_q;
    logic        start_l4;
    logic        emit_late;
    logic        pend_q;
    logic [15:0] pend_len_q;
    logic        pend_err_q;
    logic        pend_tagv_q;
    logic [63:0] pend_tag_q;

    // Upper half of each word is kept for realigning lane-4 frames.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            hold_rxd_q <= '0;
            hold_rxc_q <= '0;
        end else begin
            hold_rxd_q <= xgmii_rxd[63:32];
            hold_rxc_q <= xgmii_rxc[7:4];
        end
    end

    // Lanes 4-7 of the previous word come first on the wire, so they become
    // effective lanes 0-3 of the realigned word.
    always_comb begin
        eff_rxd = xgmii_rxd;
        eff_rxc = xgmii_rxc;
        if (align_q) begin
            eff_rxd = {xgmii_rxd[31:0], hold_rxd_q};
            eff_rxc = {xgmii_rxc[3:0], hold_rxc_q};
        end
    end

    assign start_l4     = xgmii_rxc[4] && (xgmii_rxd[39:32] == C_START) && (&xgmii_rxc[3:0]);
    assign process_word = !skip_q;
    assign emit_now     = emit && !emit_late;
`else
    assign eff_rxd      = xgmii_rxd;
    assign eff_rxc      = xgmii_rxc;
    assign process_word = 1'b1;
    assign emit_now     = emit;
`endif

    assign start_l0 = xgmii_rxc[0] && (xgmii_rxd[7:0] == C_START);

    // Lowest control lane of the effective word and the character it holds.
    always_comb begin
        ctl_found = |eff_rxc;
        ctl_lane  = 3'd0;
        ctl_byte  = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            if (eff_rxc[i]) begin
                ctl_lane = 3'(i);
                ctl_byte = eff_rxd[8*i +: 8];
            end
        end
    end

    // Saturating byte arithmetic; bit 16 flags an overflow past 16'hFFFF.
    assign sum_word  = {1'b0, byte_cnt_q} + 17'd8;
    assign sum_lane  = {1'b0, byte_cnt_q} + {14'd0, ctl_lane};
    assign cnt_plus8 = sum_word[16] ? 16'hFFFF : sum_word[15:0];
    assign len_lane  = sum_lane[16] ? 16'hFFFF : sum_lane[15:0];

    // FSM state register.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            sat_q      <= 1'b0;
            tag_q      <= '0;
            tag_hit_q  <= 1'b0;
`ifdef XGMII_LANE4_START_EN
            align_q    <= 1'b0;
            skip_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            sat_q      <= sat_d;
            tag_q      <= tag_d;
            tag_hit_q  <= tag_hit_d;
`ifdef XGMII_LANE4_START_EN
            align_q    <= align_d;
            skip_q     <= skip_d;
`endif
        end
    end

    // Next-state, byte counting, tag capture and end-of-frame decisions.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        sat_d      = sat_q;
        tag_d      = tag_q;
        tag_hit_d  = tag_hit_q;
        emit       = 1'b0;
        emit_len   = 16'd0;
        emit_err   = 1'b0;
`ifdef XGMII_LANE4_START_EN
        align_d    = align_q;
        skip_d     = 1'b0;
        emit_late  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_l0) begin
                    state_d    = S_DATA;
                    byte_cnt_d = 16'd0;
                    sat_d      = 1'b0;
                    tag_hit_d  = 1'b0;
`ifdef XGMII_LANE4_START_EN
                    align_d    = 1'b0;
                end else if (start_l4) begin
                    state_d    = S_DATA;
                    byte_cnt_d = 16'd0;
                    sat_d      = 1'b0;
                    tag_hit_d  = 1'b0;
                    align_d    = 1'b1;
                    // the word after a lane-4 Start still carries preamble
                    skip_d     = 1'b1;
`endif
                end
            end
            S_DATA: begin
                if (process_word) begin
                    if (!ctl_found) begin
                        if (byte_cnt_q == 16'(TS_OFFSET)) begin
                            tag_d     = eff_rxd;
                            tag_hit_d = 1'b1;
                        end
                        byte_cnt_d = cnt_plus8;
                        sat_d      = sat_q | sum_word[16];
                    end else begin
                        emit     = 1'b1;
                        emit_len = len_lane;
`ifdef XGMII_LANE4_START_EN
                        // real lanes 0-3 of this word: hold one more cycle so
                        // every realigned frame reports with the same latency
                        emit_late = align_q && ctl_lane[2];
`endif
                        if (ctl_byte == C_TERM) begin
                            emit_err = sat_q | sum_lane[16];
                            state_d  = S_IDLE;
                        end else begin
                            emit_err = 1'b1;
                            if ((ctl_lane == 3'd0) && (ctl_byte == C_START)) begin
                                byte_cnt_d = 16'd0;
                                sat_d      = 1'b0;
                                tag_hit_d  = 1'b0;
`ifdef XGMII_LANE4_START_EN
                                skip_d     = align_q;
`endif
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_frame = (state_q == S_DATA);

    // Per-frame report: one-cycle pulse, fields hold until the next report.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            frame_valid <= 1'b0;
            frame_len   <= '0;
            frame_err   <= 1'b0;
            tag_valid   <= 1'b0;
            tag_value   <= '0;
        end else begin
            frame_valid <= 1'b0;
            if (emit_now) begin
                frame_valid <= 1'b1;
                frame_len   <= emit_len;
                frame_err   <= emit_err;
                tag_valid   <= tag_hit_q;
                tag_value   <= tag_q;
`ifdef XGMII_LANE4_START_EN
            end else if (pend_q) begin
                frame_valid <= 1'b1;
                frame_len   <= pend_len_q;
                frame_err   <= pend_err_q;
                tag_valid   <= pend_tagv_q;
                tag_value   <= pend_tag_q;
`endif
            end
        end
    end

`ifdef XGMII_LANE4_START_EN
    // One-deep holding stage for realigned frames that end early in a word.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            pend_q      <= 1'b0;
            pend_len_q  <= '0;
            pend_err_q  <= 1'b0;
            pend_tagv_q <= 1'b0;
            pend_tag_q  <= '0;
        end else begin
            pend_q <= emit && emit_late;
            if (emit && emit_late) begin
                pend_len_q  <= emit_len;
                pend_err_q  <= emit_err;
                pend_tagv_q <= tag_hit_q;
                pend_tag_q  <= tag_q;
            end
        end
    end
`endif

    // Statistics, updated from the reported frame; a clear overrides it.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            rx_frames <= '0;
            rx_bytes  <= '0;
            rx_runts  <= '0;
            rx_errors <= '0;
        end else if (stats_clr) begin
            rx_frames <= '0;
            rx_bytes  <= '0;
            rx_runts  <= '0;
            rx_errors <= '0;
        end else if (frame_valid) begin
            if (frame_err) begin
                rx_errors <= rx_errors + 1'b1;
            end else begin
                rx_frames <= rx_frames + 1'b1;
                rx_bytes  <= rx_bytes + CNT_W'(frame_len);
                if (frame_len < 16'(MIN_LEN))
                    rx_runts <= rx_runts + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_xgmii_rx_frame_parser.sv
// Directed bench for xgmii_rx_frame_parser with hand-computed expectations.
module tb_xgmii_rx_frame_parser;

    localparam logic [63:0] W_IDLE  = 64'h0707_0707_0707_0707;
    localparam logic [63:0] W_START = 64'hD555_5555_5555_55FB;
    localparam logic [63:0] W_TAG   = 64'h0123_4567_89AB_CDEF;

    logic        sys_clk;
    logic        sys_rst;
    logic [63:0] xgmii_rxd;
    logic [7:0]  xgmii_rxc;
    logic        stats_clr;
    logic        frame_valid;
    logic [15:0] frame_len;
    logic        frame_err;
    logic        tag_valid;
    logic [63:0] tag_value;
    logic        in_frame;
    logic [31:0] rx_frames;
    logic [31:0] rx_bytes;
    logic [31:0] rx_runts;
    logic [31:0] rx_errors;

    int n_checks;
    int n_fail;

    xgmii_rx_frame_parser #(
        .TS_OFFSET (40),
        .MIN_LEN   (64),
        .CNT_W     (32)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .xgmii_rxd   (xgmii_rxd),
        .xgmii_rxc   (xgmii_rxc),
        .stats_clr   (stats_clr),
        .frame_valid (frame_valid),
        .frame_len   (frame_len),
        .frame_err   (frame_err),
        .tag_valid   (tag_valid),
        .tag_value   (tag_value),
        .in_frame    (in_frame),
        .rx_frames   (rx_frames),
        .rx_bytes    (rx_bytes),
        .rx_runts    (rx_runts),
        .rx_errors   (rx_errors)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one word, let the DUT sample it, then settle past the edge.
    task automatic tick(input logic [63:0] d, input logic [7:0] c);
        xgmii_rxd = d;
        xgmii_rxc = c;
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [63:0] dword(input int i);
        if (i == 5)
            return W_TAG;
        return {32'hA5A5_5A5A, i[31:0]};
    endfunction

    // Data in lanes below k, code in lane k, idle above.
    function automatic logic [63:0] ctl_word(input int k, input logic [7:0] code);
        logic [63:0] w;
        w = '0;
        for (int j = 0; j < 8; j++) begin
            if (j < k)       w[8*j +: 8] = 8'hAA;
            else if (j == k) w[8*j +: 8] = code;
            else             w[8*j +: 8] = 8'h07;
        end
        return w;
    endfunction

    function automatic logic [7:0] ctl_mask(input int k);
        logic [7:0] m;
        m = '0;
        for (int j = 0; j < 8; j++)
            if (j >= k) m[j] = 1'b1;
        return m;
    endfunction

    task automatic send_frame(input int nwords, input int k, input logic [7:0] code);
        tick(W_START, 8'h01);
        for (int i = 0; i < nwords; i++)
            tick(dword(i), 8'h00);
        tick(ctl_word(k, code), ctl_mask(k));
    endtask

    int fv_seen;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        fv_seen   = 0;
        sys_rst   = 1'b0;
        stats_clr = 1'b0;
        xgmii_rxd = W_IDLE;
        xgmii_rxc = 8'hFF;

        // reset state
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_fv", frame_valid, 0);
        chk("rst_len", frame_len, 0);
        chk("rst_tag", tag_value, 0);
        chk("rst_inframe", in_frame, 0);
        chk("rst_frames", rx_frames, 0);
        chk("rst_errors", rx_errors, 0);
        sys_rst = 1'b1;
        tick(W_IDLE, 8'hFF);
        tick(W_IDLE, 8'hFF);

        // minimum frame: 64 bytes, FD in lane 0
        tick(W_START, 8'h01);
        chk("min_inframe", in_frame, 1);
        for (int i = 0; i < 8; i++)
            tick(dword(i), 8'h00);
        chk("min_fv_early", frame_valid, 0);
        tick(ctl_word(0, 8'hFD), 8'hFF);
        chk("min_fv", frame_valid, 1);
        chk("min_len", frame_len, 64);
        chk("min_err", frame_err, 0);
        chk("min_tagv", tag_valid, 1);
        tick(W_IDLE, 8'hFF);
        chk("min_fv_pulse", frame_valid, 0);
        chk("min_inframe_end", in_frame, 0);
        chk("min_frames", rx_frames, 1);
        chk("min_bytes", rx_bytes, 64);
        chk("min_runts", rx_runts, 0);

        // 128-byte frame with the tag in word 5
        send_frame(16, 0, 8'hFD);
        chk("tag_fv", frame_valid, 1);
        chk("tag_len", frame_len, 128);
        chk("tag_valid", tag_valid, 1);
        chk("tag_value", tag_value, W_TAG);
        tick(W_IDLE, 8'hFF);
        chk("tag_frames", rx_frames, 2);
        chk("tag_bytes", rx_bytes, 192);

        // 40-byte runt: terminate word sits at the tag offset, no tag
        send_frame(5, 0, 8'hFD);
        chk("runt_len", frame_len, 40);
        chk("runt_tagv", tag_valid, 0);
        chk("runt_err", frame_err, 0);
        tick(W_IDLE, 8'hFF);
        chk("runt_runts", rx_runts, 1);
        chk("runt_frames", rx_frames, 3);
        chk("runt_bytes", rx_bytes, 232);

        // odd length: FD in lane 3 after 64 bytes
        send_frame(8, 3, 8'hFD);
        chk("odd_len", frame_len, 67);
        chk("odd_err", frame_err, 0);
        tick(W_IDLE, 8'hFF);
        chk("odd_runts", rx_runts, 1);
        chk("odd_bytes", rx_bytes, 299);

        // error character in lane 2 after 32 bytes
        send_frame(4, 2, 8'hFE);
        chk("err_fv", frame_valid, 1);
        chk("err_err", frame_err, 1);
        chk("err_len", frame_len, 34);
        tick(W_IDLE, 8'hFF);
        chk("err_errors", rx_errors, 1);
        chk("err_frames", rx_frames, 4);
        send_frame(8, 0, 8'hFD);
        chk("post_err_len", frame_len, 64);
        chk("post_err_err", frame_err, 0);
        tick(W_IDLE, 8'hFF);
        chk("post_err_frames", rx_frames, 5);
        chk("post_err_bytes", rx_bytes, 363);

        // restart: Start in lane 0 after 24 bytes
        tick(W_START, 8'h01);
        for (int i = 0; i < 3; i++)
            tick(dword(i), 8'h00);
        tick(W_START, 8'h01);
        chk("rs_fv", frame_valid, 1);
        chk("rs_err", frame_err, 1);
        chk("rs_len", frame_len, 24);
        chk("rs_inframe", in_frame, 1);
        for (int i = 0; i < 8; i++) begin
            tick(dword(i), 8'h00);
            if (i == 0)
                chk("rs_errors", rx_errors, 2);
        end
        tick(ctl_word(0, 8'hFD), 8'hFF);
        chk("rs_good_fv", frame_valid, 1);
        chk("rs_good_len", frame_len, 64);
        chk("rs_good_err", frame_err, 0);
        chk("rs_pre_clr_frames", rx_frames, 5);
        stats_clr = 1'b1;
        tick(W_IDLE, 8'hFF);
        stats_clr = 1'b0;
        chk("clr_frames", rx_frames, 0);
        chk("clr_bytes", rx_bytes, 0);
        chk("clr_runts", rx_runts, 0);
        chk("clr_errors", rx_errors, 0);

        // asynchronous reset in the middle of a frame
        tick(W_START, 8'h01);
        for (int i = 0; i < 3; i++)
            tick(dword(i), 8'h00);
        sys_rst = 1'b0;
        #1;
        chk("mrst_inframe", in_frame, 0);
        chk("mrst_len", frame_len, 0);
        chk("mrst_tagv", tag_valid, 0);
        chk("mrst_fv", frame_valid, 0);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b1;
        for (int i = 3; i < 8; i++) begin
            tick(dword(i), 8'h00);
            if (frame_valid) fv_seen++;
        end
        tick(ctl_word(0, 8'hFD), 8'hFF);
        if (frame_valid) fv_seen++;
        tick(W_IDLE, 8'hFF);
        if (frame_valid) fv_seen++;
        chk("mrst_no_fv", fv_seen, 0);
        chk("mrst_frames", rx_frames, 0);
        send_frame(8, 0, 8'hFD);
        chk("mrst_next_len", frame_len, 64);
        tick(W_IDLE, 8'hFF);
        chk("mrst_next_frames", rx_frames, 1);

`ifdef XGMII_LANE4_START_EN
        // lane-4 Start: 64-byte frame realigned by 4 bytes, FD in real lane 4
        tick(W_IDLE, 8'hFF);
        tick(64'h5555_55FB_0707_0707, 8'h1F);
        chk("l4_inframe", in_frame, 1);
        tick({32'h1111_1111, 32'hD555_5555}, 8'h00);
        for (int i = 2; i < 9; i++)
            tick(dword(i), 8'h00);
        tick({24'h0707_07, 8'hFD, 32'h2222_2222}, 8'hF0);
        chk("l4_fv_lat1", frame_valid, 0);
        tick(W_IDLE, 8'hFF);
        chk("l4_fv_lat2", frame_valid, 1);
        chk("l4_len", frame_len, 64);
        chk("l4_err", frame_err, 0);
        tick(W_IDLE, 8'hFF);
        chk("l4_frames", rx_frames, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
